// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg: shared state encoding, address-width default and halfword select
// for the 32-bit-to-16-bit SRAM controller.
package sram_ctl_pkg;

    localparam int SRAM_AW_DEF = 18;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    function automatic logic [15:0] half_sel(input logic [31:0] d, input logic h);
        return h ? d[31:16] : d[15:0];
    endfunction

endpackage

// File: rtl/sram_wait_ctr.sv
// sram_wait_ctr: 4-bit wait-state down-counter; zero marks the last strobe cycle.
module sram_wait_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       count,
    input  logic [3:0] value,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (count && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign zero = cnt == 4'd0;

endmodule

// File: rtl/sram_ctl.sv
// sram_ctl: splits each 32-bit request into two 16-bit asynchronous SRAM accesses,
// low halfword first, with SETUP / WAIT-cycle STROBE / write-only HOLD phases.
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int WAIT    = 2,
    parameter int SRAM_AW = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sstb,
    output logic               sack,
    input  logic [31:0]        saddr,
    input  logic [31:0]        sdtw,
    output logic [31:0]        sdtr,
    input  logic               srw,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_t             state, nstate;
    logic [SRAM_AW-2:0] addr;
    logic [31:0]        wdat;
    logic               rw, half, load, count, zero, act;
    logic               unused_addr;

    assign unused_addr = ^{saddr[31:SRAM_AW+1], saddr[1:0]};

    sram_wait_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .count (count),
        .value (4'(WAIT - 1)),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nstate;
    end

    always_comb begin
        nstate     = state;
        load       = 1'b0;
        count      = 1'b0;
        act        = state == SETUP || state == STROBE || state == HOLD;
        sack       = state == DONE;
        sram_ce_n  = !act;
        sram_oe_n  = !(state == STROBE && !rw);
        sram_we_n  = !(state == STROBE && rw);
        sram_dq_oe = act && rw;
        sram_dq_o  = sram_dq_oe ? half_sel(wdat, half) : 16'h0;
        sram_a     = {addr, half};
        case (state)
            IDLE:    nstate = sstb ? SETUP : IDLE;
            SETUP:   begin nstate = STROBE; load = 1'b1; end
            STROBE:  begin
                count = 1'b1;
                if (zero) nstate = rw ? HOLD : (half ? DONE : SETUP);
            end
            HOLD:    nstate = half ? DONE : SETUP;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            wdat <= '0;
            rw   <= 1'b0;
            half <= 1'b0;
            sdtr <= '0;
        end else begin
            if (state == IDLE && sstb) begin
                addr <= saddr[SRAM_AW:2];
                wdat <= sdtw;
                rw   <= srw;
                half <= 1'b0;
            end else if (state != IDLE && nstate == SETUP) begin
                half <= 1'b1;
            end
            // read data is taken on the final strobe cycle of each halfword
            if (state == STROBE && zero && !rw) begin
                if (half) sdtr[31:16] <= sram_dq_i;
                else sdtr[15:0] <= sram_dq_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctl.sv
// tb_sram_ctl: directed checks of sram_ctl at WAIT=2, 1 and 15 against a small SRAM model.
module tb_sram_ctl;
    import sram_ctl_pkg::*;

    localparam int AW = SRAM_AW_DEF;
    localparam int WV[3] = '{2, 1, 15};

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic          sstb[3];
    logic [31:0]   saddr, sdtw;
    logic          srw;
    logic          sack[3];
    logic [31:0]   sdtr[3];
    logic [AW-1:0] sa[3];
    logic [15:0]   dqo[3];
    logic          dqoe[3], ce_n[3], oe_n[3], we_n[3];

    logic [15:0]   wmem[64];
    logic [AW-1:0] wtag[64];
    logic [63:0]   wv = '0;

    int n_cmp = 0, n_err = 0;
    int lat, first, nsack;
    logic [31:0]   rd;
    logic [AW-1:0] a_tr[64];
    logic          we_tr[64], oe_tr[64], dqoe_tr[64];
    logic [15:0]   dqo_tr[64];

    function automatic logic [15:0] dflt(input logic [AW-1:0] a);
        return a == 8 ? 16'hBEEF : a == 9 ? 16'hCAFE : a[15:0] ^ 16'hA5A5;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : d
            logic [15:0] di;
            always_comb di = (wv[sa[g][5:0]] && wtag[sa[g][5:0]] == sa[g]) ? wmem[sa[g][5:0]] : dflt(sa[g]);
            sram_ctl #(.WAIT(WV[g]), .SRAM_AW(AW)) u (
                .clk        (clk),
                .reset      (reset),
                .sstb       (sstb[g]),
                .sack       (sack[g]),
                .saddr      (saddr),
                .sdtw       (sdtw),
                .sdtr       (sdtr[g]),
                .srw        (srw),
                .sram_a     (sa[g]),
                .sram_dq_o  (dqo[g]),
                .sram_dq_i  (di),
                .sram_dq_oe (dqoe[g]),
                .sram_ce_n  (ce_n[g]),
                .sram_oe_n  (oe_n[g]),
                .sram_we_n  (we_n[g])
            );
        end
    endgenerate

    // only instance 0 is ever given writes
    always @(negedge clk) begin
        if (!we_n[0]) begin
            wmem[sa[0][5:0]] <= dqo[0];
            wtag[sa[0][5:0]] <= sa[0];
            wv[sa[0][5:0]]   <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int u, input logic [31:0] ad, input logic [31:0] dt, input logic w, input bit keep);
        @(negedge clk);
        saddr = ad; sdtw = dt; srw = w; sstb[u] = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            a_tr[k] = sa[u]; we_tr[k] = we_n[u]; oe_tr[k] = oe_n[u];
            dqoe_tr[k] = dqoe[u]; dqo_tr[k] = dqo[u];
            chk("we_oe_excl", 32'(we_n[u] | oe_n[u]), 32'd1);
            if (!w) chk("rd_dqoe", 32'(dqoe[u]), 32'd0);
            if (sack[u]) begin
                lat = k; rd = sdtr[u];
                if (!keep) sstb[u] = 1'b0;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++; n_err++; sstb[u] = 1'b0;
            $error("FAIL sack_timeout: observed none expected sack within 63 cycles");
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sstb[i] = 1'b0;
        saddr = '0; sdtw = '0; srw = 1'b0;
        #2;
        chk("rst_sack", 32'(sack[0]), 0);
        chk("rst_ce_n", 32'(ce_n[0]), 1);
        chk("rst_oe_n", 32'(oe_n[0]), 1);
        chk("rst_we_n", 32'(we_n[0]), 1);
        chk("rst_dqoe", 32'(dqoe[0]), 0);
        chk("rst_a", 32'(sa[0]), 0);
        chk("rst_dqo", 32'(dqo[0]), 0);
        chk("rst_sdtr", sdtr[0], 0);
        @(negedge clk); reset = 1'b1;

        xact(0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("rd_lat", lat, 7);
        chk("rd_data", rd, 32'hCAFEBEEF);
        chk("rd_a0", 32'(a_tr[1]), 8);
        chk("rd_a1", 32'(a_tr[4]), 9);
        chk("rd_oe2", 32'(oe_tr[2]), 0);
        chk("rd_oe3", 32'(oe_tr[3]), 0);
        chk("rd_oe4", 32'(oe_tr[4]), 1);

        xact(0, 32'h20, 32'h12345678, 1'b1, 1'b0);
        chk("wr_lat", lat, 9);
        chk("wr_a0", 32'(a_tr[1]), 16);
        chk("wr_dq0", 32'(dqo_tr[1]), 32'h5678);
        chk("wr_oe_setup0", 32'(dqoe_tr[1]), 1);
        chk("wr_we1", 32'(we_tr[1]), 1);
        chk("wr_we2", 32'(we_tr[2]), 0);
        chk("wr_we3", 32'(we_tr[3]), 0);
        chk("wr_we4", 32'(we_tr[4]), 1);
        chk("wr_oe_hold0", 32'(dqoe_tr[4]), 1);
        chk("wr_we5", 32'(we_tr[5]), 1);
        chk("wr_a1", 32'(a_tr[5]), 17);
        chk("wr_dq1", 32'(dqo_tr[5]), 32'h1234);
        chk("wr_we6", 32'(we_tr[6]), 0);
        chk("wr_we7", 32'(we_tr[7]), 0);
        chk("wr_oe_hold1", 32'(dqoe_tr[8]), 1);
        chk("wr_oe_done", 32'(dqoe_tr[9]), 0);
        chk("wr_keeps_sdtr", sdtr[0], 32'hCAFEBEEF);

        xact(0, 32'h10, 32'h0, 1'b0, 1'b1);
        chk("b2b_lat0", lat, 7);
        saddr = 32'h20; srw = 1'b0;
        first = 0; nsack = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) chk("b2b_idle_ce", 32'(ce_n[0]), 1);
            if (k == 2) chk("b2b_setup_ce", 32'(ce_n[0]), 0);
            if (k == 2) chk("b2b_setup_a", 32'(sa[0]), 16);
            if (sack[0]) begin
                nsack++;
                if (first == 0) first = k;
                sstb[0] = 1'b0;
            end
        end
        chk("b2b_lat1", first, 8);
        chk("b2b_nsack", nsack, 1);
        chk("b2b_data", sdtr[0], 32'h12345678);

        @(negedge clk);
        saddr = 32'h40; sdtw = 32'hAAAA5555; srw = 1'b1; sstb[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("abort_pre_we", 32'(we_n[0]), 0);
        reset = 1'b0;
        #1;
        chk("abort_we_n", 32'(we_n[0]), 1);
        chk("abort_ce_n", 32'(ce_n[0]), 1);
        chk("abort_dqoe", 32'(dqoe[0]), 0);
        chk("abort_a", 32'(sa[0]), 0);
        chk("abort_sdtr", sdtr[0], 0);
        sstb[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_sack", 32'(sack[0]), 0);
        end
        reset = 1'b1;
        xact(0, 32'h40, 32'h0, 1'b0, 1'b0);
        chk("abort_nowrite", rd, 32'hA584A585);
        xact(0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("post_rst_rd", rd, 32'hCAFEBEEF);

        xact(1, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("w1_lat", lat, 5);
        chk("w1_data", rd, 32'hCAFEBEEF);
        xact(2, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("w15_lat", lat, 33);
        chk("w15_data", rd, 32'hCAFEBEEF);

        xact(0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        chk("top_a0", 32'(a_tr[1]), 32'h3FFFE);
        chk("top_a1", 32'(a_tr[4]), 32'h3FFFF);
        chk("top_data", rd, 32'h5A5A5A5B);
        xact(0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0);
        chk("top_lowbits", rd, 32'h5A5A5A5B);
        xact(0, 32'h00080010, 32'h0, 1'b0, 1'b0);
        chk("alias_data", rd, 32'hCAFEBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
